// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N systolic MAC array: skewed operand feed, per-PE clear, row-wise drain.
// Optional macro SYSTOLIC_CTRL_PERF_CNT_EN adds the perf_cycles busy-cycle counter output.
module systolic_ctrl #(
  parameter int N     = 4,
  parameter int K_W   = 8,
  parameter int ROW_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [K_W-1:0]     k_len,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       a_feed_en,
  output logic [N*K_W-1:0]   a_feed_idx,
  output logic [N-1:0]       b_feed_en,
  output logic [N*K_W-1:0]   b_feed_idx,
  output logic [N*N-1:0]     pe_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROW_W-1:0]   out_row,
  output logic [1:0]         dbg_state
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        perf_cycles
`endif
);

  localparam int T_W = K_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_OUT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [T_W-1:0]    t_q, t_d, t_end;
  logic [K_W-1:0]    k_q, k_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [N-1:0]      feed_en_q, feed_en_d;
  logic [N*K_W-1:0]  feed_idx_q, feed_idx_d;
  logic [N*N-1:0]    clear_q, clear_d;

  assign t_end = T_W'(k_q) - T_W'(1) + T_W'(2 * (N - 1));

  // Handshake: a row transfers on any cycle where out_valid & out_ready; while
  // out_ready is low the offered row (out_valid, out_row) holds indefinitely.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    k_d     = k_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start && (k_len != '0)) begin
          state_d = S_FEED;
          t_d     = '0;
          k_d     = k_len;
        end
      end
      S_FEED: begin
        if (t_q == t_end) begin
          state_d = S_OUT;
          t_d     = '0;
          row_d   = '0;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (row_q == ROW_W'(N - 1)) begin
            state_d = S_DONE;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in the same cycle as t.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    valid_d    = (state_d == S_OUT);
    feed_en_d  = '0;
    feed_idx_d = '0;
    clear_d    = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        if ((t_d >= T_W'(i)) && ((t_d - T_W'(i)) < T_W'(k_d))) begin
          feed_en_d[i]                = 1'b1;
          feed_idx_d[i*K_W +: K_W]    = K_W'(t_d - T_W'(i));
        end
        for (int j = 0; j < N; j++) begin
          clear_d[i*N + j] = (t_d == T_W'(i + j));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      k_q        <= '0;
      row_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      feed_en_q  <= '0;
      feed_idx_q <= '0;
      clear_q    <= '0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      k_q        <= k_d;
      row_q      <= row_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      feed_en_q  <= feed_en_d;
      feed_idx_q <= feed_idx_d;
      clear_q    <= clear_d;
    end
  end

  // Row and column edges share one skew schedule, so one register set drives both.
  assign busy       = busy_q;
  assign done       = done_q;
  assign a_feed_en  = feed_en_q;
  assign b_feed_en  = feed_en_q;
  assign a_feed_idx = feed_idx_q;
  assign b_feed_idx = feed_idx_q;
  assign pe_clear   = clear_q;
  assign out_valid  = valid_q;
  assign out_row    = row_q;
  assign dbg_state  = state_q;

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Restarts at 1 on accept because that edge already begins the first busy cycle.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && (state_d == S_FEED)) begin
      perf_d = 32'd1;
    end else if (busy_d && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  // No performance counter in this build.
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (N=2) with an integer array/buffer model checking drained rows.
module tb_systolic_ctrl;

  localparam int N     = 2;
  localparam int K_W   = 8;
  localparam int ROW_W = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start, out_ready;
  logic [K_W-1:0]     k_len;
  logic               busy, done, out_valid;
  logic [N-1:0]       a_feed_en, b_feed_en;
  logic [N*K_W-1:0]   a_feed_idx, b_feed_idx;
  logic [N*N-1:0]     pe_clear;
  logic [ROW_W-1:0]   out_row;
  logic [1:0]         dbg_state;
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  logic [31:0]        perf_cycles;
`endif

  systolic_ctrl #(.N(N), .K_W(K_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done),
    .a_feed_en(a_feed_en), .a_feed_idx(a_feed_idx),
    .b_feed_en(b_feed_en), .b_feed_idx(b_feed_idx),
    .pe_clear(pe_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .dbg_state(dbg_state)
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // ---------------- array + operand buffer model ----------------
  // A[i][k] = a_sign*(4i+k+1), B[k][j] = 2k+j+1; outside the window edges are 0.
  int a_sign;
  int acc [N][N];
  int ar  [N][N];
  int br  [N][N];

  function automatic int edge_a(input int i);
    int idx;
    idx = int'(a_feed_idx[i*K_W +: K_W]);
    return a_feed_en[i] ? a_sign * (4 * i + idx + 1) : 0;
  endfunction

  function automatic int edge_b(input int j);
    int idx;
    idx = int'(b_feed_idx[j*K_W +: K_W]);
    return b_feed_en[j] ? (2 * idx + j + 1) : 0;
  endfunction

  always @(negedge clk) begin : array_model
    int na [N][N];
    int nb [N][N];
    int ain, bin;
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) ain = edge_a(i); else ain = ar[i][j-1];
          if (i == 0) bin = edge_b(j); else bin = br[i-1][j];
          na[i][j] = ain;
          nb[i][j] = bin;
          if (pe_clear[i*N + j]) acc[i][j] = ain * bin;
          else                   acc[i][j] = acc[i][j] + ain * bin;
        end
      ar = na;
      br = nb;
    end
  end

  function automatic logic [31:0] c_row(input int r);
    logic [31:0] v0, v1;
    v0 = acc[r][0];
    v1 = acc[r][1];
    return {v1[15:0], v0[15:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_row(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(c_row(int'(out_row))), 64'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start in "cycle 0" and returns in cycle 1.
  task automatic launch(input logic [K_W-1:0] k);
    start = 1'b1;
    k_len = k;
    tick();
    start = 1'b0;
    k_len = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b1; a_sign = 1;
    tick();
    check("rst_outputs", 64'({busy, done, a_feed_en, b_feed_en, pe_clear, out_valid, out_row}), 64'd0);
    check("rst_idx", 64'({a_feed_idx, b_feed_idx}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Job 1: K=3, ready high. C = [[22,28],[58,76]].
    exp_q.push_back(32'h001C_0016);
    exp_q.push_back(32'h004C_003A);
    launch(8'd3);
    check("j1_c1_busy", 64'(busy), 64'd1);
    check("j1_c1_a_en", 64'(a_feed_en), 64'b01);
    check("j1_c1_b_en", 64'(b_feed_en), 64'b01);
    check("j1_c1_clr", 64'(pe_clear), 64'b0001);
    check("j1_c1_idx", 64'(a_feed_idx), 64'h0000);
    tick();
    check("j1_c2_a_en", 64'(a_feed_en), 64'b11);
    check("j1_c2_clr", 64'(pe_clear), 64'b0110);
    check("j1_c2_idx", 64'({a_feed_idx, b_feed_idx}), 64'h0001_0001);
    tick();
    check("j1_c3_clr", 64'(pe_clear), 64'b1000);
    check("j1_c3_idx", 64'(b_feed_idx), 64'h0102);
    tick();
    check("j1_c4_en", 64'({a_feed_en, b_feed_en}), 64'b1010);
    check("j1_c4_idx", 64'(a_feed_idx), 64'h0200);
    check("j1_c4_clr", 64'(pe_clear), 64'b0000);
    tick();
    check("j1_c5_en", 64'({a_feed_en, b_feed_en}), 64'd0);
    check("j1_c5_busy_valid", 64'({busy, out_valid}), 64'b10);
    tick();
    check("j1_c6_valid_row", 64'({out_valid, out_row}), 64'b10);
    check_row("j1_row0");
    tick();
    check("j1_c7_valid_row", 64'({out_valid, out_row}), 64'b11);
    check_row("j1_row1");
    tick();
    check("j1_c8_done_busy_valid", 64'({done, busy, out_valid}), 64'b110);
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    check("j1_perf", 64'(perf_cycles), 64'd8);
`endif
    tick();
    check("j1_c9_idle", 64'({done, busy}), 64'd0);

    // Job 2: negated A (restart via clear), 4 stall cycles at row 0, start pulsed during OUT.
    a_sign = -1;
    exp_q.push_back(32'hFFE4_FFEA);
    exp_q.push_back(32'hFFB4_FFC6);
    launch(8'd3);
    repeat (5) tick();
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("j2_stall%0d_valid_row", s), 64'({out_valid, out_row}), 64'b10);
      check($sformatf("j2_stall%0d_done", s), 64'(done), 64'd0);
      if (s == 1) begin
        start = 1'b1;
        k_len = 8'd3;
      end else begin
        start = 1'b0;
        k_len = '0;
      end
      tick();
    end
    out_ready = 1'b1;
    check("j2_c10_valid_row", 64'({out_valid, out_row}), 64'b10);
    check_row("j2_row0");
    tick();
    check("j2_c11_valid_row", 64'({out_valid, out_row}), 64'b11);
    check_row("j2_row1");
    tick();
    check("j2_c12_done", 64'({done, busy}), 64'b11);
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    check("j2_perf", 64'(perf_cycles), 64'd12);
`endif
    tick();
    check("j2_c13_start_ignored", 64'({busy, dbg_state}), 64'd0);
    tick();
    check("j2_c14_still_idle", 64'({busy, a_feed_en, done}), 64'd0);

    // k_len = 0 is ignored.
    launch(8'd0);
    check("k0_c1", 64'({busy, a_feed_en, b_feed_en, pe_clear, dbg_state}), 64'd0);
    tick();
    tick();
    check("k0_c3", 64'({busy, done, out_valid}), 64'd0);

    // Reset in FEED at t=2, then a K=1 job.
    a_sign = 1;
    launch(8'd3);
    tick();
    tick();
    check("rstmid_pre_clr", 64'(pe_clear), 64'b1000);
    rst = 1'b1;
    #1;
    check("rstmid_outputs", 64'({busy, done, a_feed_en, b_feed_en, pe_clear, out_valid, out_row}), 64'd0);
    check("rstmid_idx_state", 64'({a_feed_idx, b_feed_idx, dbg_state}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rstmid_no_done", 64'({done, busy}), 64'd0);
    exp_q.push_back(32'h0002_0001);
    exp_q.push_back(32'h000A_0005);
    launch(8'd1);
    check("k1_c1_clr", 64'(pe_clear), 64'b0001);
    repeat (3) tick();
    check("k1_c4_valid_row", 64'({out_valid, out_row}), 64'b10);
    check_row("k1_row0");
    tick();
    check("k1_c5_valid_row", 64'({out_valid, out_row, done}), 64'b110);
    check_row("k1_row1");
    tick();
    check("k1_c6_done", 64'({done, busy}), 64'b11);
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    check("k1_perf", 64'(perf_cycles), 64'd6);
`endif
    tick();
    check("k1_c7_idle", 64'({done, busy}), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
